// File: rtl/rv_mul_pkg.sv
// Shared types and constants for the byte-slice multiplier: FSM state encoding,
// byte-select width, term count and the (i,j) -> term index mapping.
package rv_mul_pkg;

  localparam int SEL_W   = 2;
  localparam int N_TERMS = 10;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Terms are numbered by diagonal: index = s*(s+1)/2 + i where s = i+j.
  // Pairs with i+j > 3 have no slot and map to 0.
  function automatic logic [3:0] term_idx(input logic [SEL_W-1:0] i,
                                          input logic [SEL_W-1:0] j);
    logic [2:0] s;
    logic [3:0] ix;
    s  = {1'b0, i} + {1'b0, j};
    ix = {2'b00, i};
    case (s)
      3'd0:    term_idx = 4'd0;
      3'd1:    term_idx = 4'd1 + ix;
      3'd2:    term_idx = 4'd3 + ix;
      3'd3:    term_idx = 4'd6 + ix;
      default: term_idx = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_mul_pp.sv
// Partial-product generator: selects one byte of each operand, forms the
// 16-bit product, then shifts it left and truncates to 32 bits.
module rv_mul_pp
  import rv_mul_pkg::*;
(
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [SEL_W-1:0] a_sel,
  input  logic [SEL_W-1:0] b_sel,
  input  logic [4:0]       shift_val,
  output logic [31:0]      pp
);

  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [15:0] prod;

  always_comb begin
    a_byte = op_a[{a_sel, 3'b000} +: 8];
    b_byte = op_b[{b_sel, 3'b000} +: 8];
    prod   = a_byte * b_byte;
    pp     = {16'h0000, prod} << shift_val;
  end

endmodule

// File: rtl/rv_mul_unit.sv
// Multicycle multiplier accumulator driven by the MUL1..MUL10 control strobes.
// Define MUL_CHECK_EN to add the term-protocol checker and the mul_err output.
module rv_mul_unit
  import rv_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic [SEL_W-1:0] Ma_sel,
  input  logic [SEL_W-1:0] Mb_sel,
  input  logic [4:0]       Mshift_val,
  input  logic             Mupd_reg,
  input  logic             Mclr_reg,
  output logic [31:0]      mul_res,
  output logic             mul_busy,
  output logic             mul_done
`ifdef MUL_CHECK_EN
  ,
  output logic             mul_err
`endif
);

  // Strobe protocol: Mupd_reg is a one-cycle-per-term command with no
  // back-pressure; Mclr_reg wins over Mupd_reg when both are high.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      acc;
  logic [31:0]      pp;

  rv_mul_pp u_pp (
    .op_a      (op_a),
    .op_b      (op_b),
    .a_sel     (Ma_sel),
    .b_sel     (Mb_sel),
    .shift_val (Mshift_val),
    .pp        (pp)
  );

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (Mclr_reg) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (Mupd_reg) begin
      if (state == ST_ACC) begin
        acc <= acc + pp;
        cnt <= cnt_nxt;
        if (cnt_nxt == LAST_CNT) state <= ST_DONE;
      end else begin
        // An update from IDLE or DONE begins a fresh multiply.
        acc   <= pp;
        cnt   <= CNT_W'(1);
        state <= ST_ACC;
      end
    end
  end

  assign mul_res  = acc;
  assign mul_busy = (state == ST_ACC);
  assign mul_done = (state == ST_DONE);

`ifdef MUL_CHECK_EN
  logic [2:0] sel_sum;
  logic       range_bad;
  logic       shift_bad;
  logic       dup_bad;
  logic [9:0] term_oh;
  logic [9:0] mask;
  logic       err;

  always_comb begin
    sel_sum   = {1'b0, Ma_sel} + {1'b0, Mb_sel};
    range_bad = (sel_sum > 3'd3);
    shift_bad = ({1'b0, Mshift_val} != {sel_sum, 3'b000});
    term_oh   = range_bad ? 10'b0 : (10'b1 << term_idx(Ma_sel, Mb_sel));
    // The mask is restarted on entry to ACC, so only ACC can see a repeat.
    dup_bad   = (state == ST_ACC) && ((mask & term_oh) != 10'b0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      err  <= 1'b0;
    end else if (Mclr_reg) begin
      mask <= '0;
      err  <= 1'b0;
    end else if (Mupd_reg) begin
      mask <= (state == ST_ACC) ? (mask | term_oh) : term_oh;
      err  <= err | range_bad | shift_bad | dup_bad;
    end
  end

  assign mul_err = err;
`endif

endmodule

// File: tb/tb_rv_mul_unit.sv
// Directed self-checking bench for rv_mul_unit; the checker tests run only when
// MUL_CHECK_EN is defined.
module tb_rv_mul_unit;

  logic        clk;
  logic        rst;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  Ma_sel;
  logic [1:0]  Mb_sel;
  logic [4:0]  Mshift_val;
  logic        Mupd_reg;
  logic        Mclr_reg;
  logic [31:0] mul_res;
  logic        mul_busy;
  logic        mul_done;
`ifdef MUL_CHECK_EN
  logic        mul_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Standard MUL1..MUL10 byte pairs (i, j); shift is 8*(i+j).
  int tbl_i [10] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3};
  int tbl_j [10] = '{0, 1, 0, 2, 1, 0, 3, 2, 1, 0};

  rv_mul_unit dut (
    .clk        (clk),
    .rst        (rst),
    .op_a       (op_a),
    .op_b       (op_b),
    .Ma_sel     (Ma_sel),
    .Mb_sel     (Mb_sel),
    .Mshift_val (Mshift_val),
    .Mupd_reg   (Mupd_reg),
    .Mclr_reg   (Mclr_reg),
    .mul_res    (mul_res),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done)
`ifdef MUL_CHECK_EN
    ,
    .mul_err    (mul_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change only just after a falling edge
  task automatic drive_term(input int i, input int j, input int sh);
    Ma_sel     = 2'(i);
    Mb_sel     = 2'(j);
    Mshift_val = 5'(sh);
    Mupd_reg   = 1'b1;
    Mclr_reg   = 1'b0;
  endtask

  task automatic apply_term(input int k);
    drive_term(tbl_i[k], tbl_j[k], 8 * (tbl_i[k] + tbl_j[k]));
  endtask

  task automatic drive_idle();
    Mupd_reg = 1'b0;
    Mclr_reg = 1'b0;
  endtask

  task automatic run_terms(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      apply_term(k);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] res,
                               input logic busy, input logic done);
    check({tag, "_res"},  mul_res,         res);
    check({tag, "_busy"}, 32'(mul_busy),   32'(busy));
    check({tag, "_done"}, 32'(mul_done),   32'(done));
  endtask

  initial begin
    rst = 1'b1;
    op_a = '0; op_b = '0;
    Ma_sel = '0; Mb_sel = '0; Mshift_val = '0;
    Mupd_reg = 1'b0; Mclr_reg = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset", 32'h0, 1'b0, 1'b0);
`ifdef MUL_CHECK_EN
    check("reset_err", 32'(mul_err), 32'h0);
`endif
    rst = 1'b0;

    // 7 * 6: done in the cycle after MUL10
    op_a = 32'd7; op_b = 32'd6;
    run_terms(0, 0);
    @(negedge clk);
    check_outputs("small_mul1", 32'h2A, 1'b1, 1'b0);
    apply_term(1);
    run_terms(2, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("small", 32'h0000002A, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs("small_hold", 32'h0000002A, 1'b0, 1'b1);

    // mixed high/low halves
    op_a = 32'h00010003; op_b = 32'h00020005;
    run_terms(0, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("mixed", 32'h000B000F, 1'b0, 1'b1);

    // all ones, twice back to back starting from DONE
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    run_terms(0, 9);
    @(negedge clk);
    check_outputs("ones1", 32'h00000001, 1'b0, 1'b1);
    apply_term(0);
    run_terms(1, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("ones2", 32'h00000001, 1'b0, 1'b1);

    // 3-cycle stall after MUL4
    op_a = 32'h00010003; op_b = 32'h00020005;
    run_terms(0, 3);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive_idle();
      check_outputs("stall", 32'h0006000F, 1'b1, 1'b0);
    end
    run_terms(4, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("stall_final", 32'h000B000F, 1'b0, 1'b1);

    // clear together with update at MUL6
    run_terms(0, 4);
    @(negedge clk);
    apply_term(5);
    Mclr_reg = 1'b1;
    @(negedge clk);
    drive_idle();
    check_outputs("clr_upd", 32'h0, 1'b0, 1'b0);
    op_a = 32'd7; op_b = 32'd6;
    run_terms(0, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("after_clr", 32'h0000002A, 1'b0, 1'b1);

    // asynchronous reset during MUL5
    op_a = 32'h00010003; op_b = 32'h00020005;
    run_terms(0, 3);
    @(negedge clk);
    apply_term(4);
    #1 check_outputs("pre_rst", 32'h0006000F, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 check_outputs("async_rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    check_outputs("rst_held", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    run_terms(0, 9);
    @(negedge clk);
    drive_idle();
    check_outputs("after_rst", 32'h000B000F, 1'b0, 1'b1);

`ifdef MUL_CHECK_EN
    // clean sequence leaves err low
    @(negedge clk);
    Mclr_reg = 1'b1;
    @(negedge clk);
    drive_idle();
    run_terms(0, 9);
    @(negedge clk);
    drive_idle();
    check("err_clean", 32'(mul_err), 32'h0);

    // wrong shift for i=1,j=1: still accumulated, err sticky
    op_a = 32'h00000100; op_b = 32'h00000100;
    @(negedge clk);
    drive_term(1, 1, 8);
    @(negedge clk);
    drive_idle();
    check("err_shift", 32'(mul_err), 32'h1);
    check("err_shift_res", mul_res, 32'h00000100);
    @(negedge clk);
    check("err_sticky", 32'(mul_err), 32'h1);
    Mclr_reg = 1'b1;
    @(negedge clk);
    drive_idle();
    check("err_cleared", 32'(mul_err), 32'h0);

    // repeated MUL2 term
    run_terms(0, 1);
    @(negedge clk);
    drive_idle();
    check("err_dup_pre", 32'(mul_err), 32'h0);
    apply_term(1);
    @(negedge clk);
    drive_idle();
    check("err_dup", 32'(mul_err), 32'h1);

    // out-of-range pair i+j > 3
    Mclr_reg = 1'b1;
    @(negedge clk);
    drive_term(2, 2, 0);
    @(negedge clk);
    drive_idle();
    check("err_range", 32'(mul_err), 32'h1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_mul_unit.md
# rv_mul_unit

Datapath-side multiplier for the multicycle RISC-V core. It responds to the control plane's MUL1–MUL10 strobes (`Ma_sel`, `Mb_sel`, `Mshift_val`, `Mupd_reg`, `Mclr_reg`) by accumulating byte-slice partial products of the two register operands. It presents the low 32 bits of the product on `mul_res` for the MUL_WB write-back (`WB_MUL_RES`). It tracks completion itself, so the control plane never needs to issue a clear.

## Interface
- `N_TERMS`, 10: number of partial products per multiply (byte pairs i+j≤3).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op_a`  in  32  rs1 operand from datapath A register; must be stable while the block is in ACC.
- `op_b`  in  32  rs2 operand from datapath B register; same stability rule as `op_a`.
- `Ma_sel`  in  2  byte index i of `op_a`.
- `Mb_sel`  in  2  byte index j of `op_b`.
- `Mshift_val`  in  5  left shift applied to the partial product.
- `Mupd_reg`  in  1  accumulate strobe, one term per cycle.
- `Mclr_reg`  in  1  synchronous clear.
- `mul_res`  out  32  registered accumulator.
- `mul_busy`  out  1  state == ACC.
- `mul_done`  out  1  state == DONE (level).
- `mul_err`  out  1  sticky protocol error; present only with `MUL_CHECK_EN`.

## Operation
- Partial product: pp = ({24'b0, op_a byte i} × {24'b0, op_b byte j}) << Mshift_val.
  - The 16-bit product is formed first, then shifted and truncated to 32 bits.
  - Accumulation is modulo 2^32.
- States: IDLE, ACC, DONE. A 4-bit counter `cnt` counts accepted terms.
- IDLE or DONE, `Mupd_reg`=1: acc ← pp, cnt ← 1, go to ACC. An update while in DONE starts a new multiply.
- ACC, `Mupd_reg`=1: acc ← acc + pp, cnt ← cnt + 1.
  - If the new cnt equals N_TERMS, go to DONE.
- ACC, `Mupd_reg`=0: hold all state. Stalls are legal.
- `Mclr_reg`=1 in any state: acc ← 0, cnt ← 0, err ← 0, go to IDLE.
  - Clear has priority over a simultaneous `Mupd_reg`.
- DONE holds `mul_res` until the next update or clear, which covers the MUL_WB cycle.
- Result: with the control plane's 10-term sequence, `mul_res` equals (op_a × op_b)[31:0]. Signedness is irrelevant for the low word.
- Any term order is accepted. Only the count of terms determines completion.

## Timing
- Reset values: `mul_res`=0, `mul_busy`=0, `mul_done`=0, `mul_err`=0, state IDLE, cnt 0.
- Reset is asynchronous and takes effect mid-operation: the block returns to IDLE with all outputs 0 immediately.
- Each update is visible on `mul_res` the cycle after its strobe.
- Latency: 10 consecutive strobes (MUL1..MUL10) put `mul_done`=1 in the following cycle (MUL_WB) with the final `mul_res`.
- No combinational path from any input to any output.

## Configuration
- `MUL_CHECK_EN` defined: adds a 10-bit term mask (cleared on entry to ACC) and `mul_err`.
  - err is set if `Mshift_val` ≠ 8·(i+j).
  - err is set if i+j > 3.
  - err is set if a term's mask bit is already set.
  - The offending term is still accumulated. err clears only on `Mclr_reg` or reset.
- `MUL_CHECK_EN` undefined: no mask, no error logic, and no `mul_err` port.

## Structure
- Shared package `rv_mul_pkg` holds:
  - the IDLE/ACC/DONE state enum;
  - the byte-select width (2);
  - `N_TERMS`;
  - the term-index mapping (i,j) → 0..9.
- `WB_MUL_RES` stays in the existing shared params include.
- One combinational sub-module, `rv_mul_pp`, performs byte select, the 8×8 multiply, shift and truncation.
- FSM, counter, accumulator and checker live in `rv_mul_unit`.

## Test plan
- op_a=7, op_b=6, standard 10-step sequence → `mul_res`=0x0000002A and `mul_done`=1 in cycle 11.
- op_a=0x00010003, op_b=0x00020005 → `mul_res`=0x000B000F.
- op_a=op_b=0xFFFFFFFF → `mul_res`=0x00000001. A second back-to-back sequence starting from DONE gives the same result with no clear.
- Deassert `Mupd_reg` for 3 cycles after MUL4 → `mul_busy` is held and the final result is unchanged. Assert `Mclr_reg` together with `Mupd_reg` at MUL6 → IDLE, `mul_res`=0.
- Assert `rst` during MUL5 → all outputs 0 asynchronously. Restarting the sequence gives the correct product.
- With `MUL_CHECK_EN`:
  - i=1, j=1, shift=8 → `mul_err`=1.
  - Repeating the MUL2 term → `mul_err`=1.
  - Clean sequence → `mul_err`=0.
